// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - shared FSM state types, status bit positions and port constants for io_uart
package io_uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_IDLE   = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_DROP   = 5;

  localparam logic [2:0] IO_N_LOOPBACK = 3'd3;

endpackage

// File: rtl/io_uart_fifo.sv
// rtl/io_uart_fifo.sv - synchronous TX byte FIFO; push when full and pop when empty are ignored
module io_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetq,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge clock) begin
    if (!resetq) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop && !o_empty) r_rptr <= r_rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/io_uart.sv
// rtl/io_uart.sv - CDP1802 I/O-bus 8N1 UART responder with TX FIFO, EF flags and status port
// Optional IO_UART_LOOPBACK_EN maps a loopback control bit at io_n=3.
module io_uart
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TX_DEPTH     = 4,
  parameter int PORT_DATA    = 1,
  parameter int PORT_STATUS  = 2
) (
  input  logic       clock,
  input  logic       resetq,
  input  logic [2:0] io_n,
  input  logic       io_inp,
  input  logic       io_out,
  input  logic [7:0] io_dout,
  output logic [7:0] io_din,
  output logic [3:0] ef,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            w_wr_data, w_rd_data, w_rd_stat;
  logic            w_fifo_full, w_fifo_empty, w_fifo_pop, w_rx_src, w_tx_idle;
  logic [7:0]      w_fifo_dout, w_status, w_din;

  tx_state_t       r_tx_state;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_tx_line;

  rx_state_t       r_rx_state;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift, r_rx_data;
  logic            r_rx_s1, r_rx_s2, r_rx_d;
  logic            r_rx_valid, r_rx_ovr, r_frame_err, r_tx_drop;

  assign w_wr_data = io_out && (io_n == 3'(PORT_DATA));
  assign w_rd_data = io_inp && (io_n == 3'(PORT_DATA));
  assign w_rd_stat = io_inp && (io_n == 3'(PORT_STATUS));

  assign w_fifo_pop = !w_fifo_empty &&
                      ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP && r_tx_cnt == CNT_LAST));
  assign w_tx_idle  = w_fifo_empty && (r_tx_state == TX_IDLE);

  io_uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .resetq  (resetq),
    .i_push  (w_wr_data),
    .i_din   (io_dout),
    .i_pop   (w_fifo_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef IO_UART_LOOPBACK_EN
  logic r_loopback;
  always_ff @(posedge clock) begin
    if (!resetq) r_loopback <= 1'b0;
    else if (io_out && io_n == IO_N_LOOPBACK) r_loopback <= io_dout[0];
  end
  assign w_rx_src = r_loopback ? r_tx_line : uart_rx;
  assign uart_tx  = r_loopback | r_tx_line;
`else
  assign w_rx_src = uart_rx;
  assign uart_tx  = r_tx_line;
`endif

  // TX: each state lasts one bit time; STOP chains straight into START when more bytes wait.
  always_ff @(posedge clock) begin
    if (!resetq) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (!w_fifo_empty) begin
          r_tx_state <= TX_START;
          r_tx_shift <= w_fifo_dout;
          r_tx_line  <= 1'b0;
          r_tx_cnt   <= '0;
        end
        TX_START: if (r_tx_cnt == CNT_LAST) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx_line  <= r_tx_shift[0];
          r_tx_state <= TX_DATA;
        end else r_tx_cnt <= r_tx_cnt + CNT_ONE;
        TX_DATA: if (r_tx_cnt == CNT_LAST) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= TX_STOP;
            r_tx_line  <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_line  <= r_tx_shift[1];
          end
        end else r_tx_cnt <= r_tx_cnt + CNT_ONE;
        TX_STOP: if (r_tx_cnt == CNT_LAST) begin
          r_tx_cnt <= '0;
          if (!w_fifo_empty) begin
            r_tx_state <= TX_START;
            r_tx_shift <= w_fifo_dout;
            r_tx_line  <= 1'b0;
          end else r_tx_state <= TX_IDLE;
        end else r_tx_cnt <= r_tx_cnt + CNT_ONE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX plus sticky flags; later assignments make a same-cycle set beat a read clear.
  always_ff @(posedge clock) begin
    if (!resetq) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_d      <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_drop   <= 1'b0;
    end else begin
      r_rx_s1 <= w_rx_src;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (w_rd_data) r_rx_valid <= 1'b0;
      if (w_rd_stat) begin
        r_rx_ovr    <= 1'b0;
        r_frame_err <= 1'b0;
        r_tx_drop   <= 1'b0;
      end
      if (w_wr_data && w_fifo_full) r_tx_drop <= 1'b1;
      case (r_rx_state)
        RX_IDLE: if (r_rx_d && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_rx_cnt == CNT_HALF) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + CNT_ONE;
        RX_DATA: if (r_rx_cnt == CNT_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else r_rx_bit <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt + CNT_ONE;
        RX_STOP: if (r_rx_cnt == CNT_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_IDLE;
          if (!r_rx_s2) r_frame_err <= 1'b1;
          else if (r_rx_valid) r_rx_ovr <= 1'b1;
          else begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
          end
        end else r_rx_cnt <= r_rx_cnt + CNT_ONE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[ST_RX_VALID]  = r_rx_valid;
    w_status[ST_TX_FULL]   = w_fifo_full;
    w_status[ST_TX_IDLE]   = w_tx_idle;
    w_status[ST_RX_OVR]    = r_rx_ovr;
    w_status[ST_FRAME_ERR] = r_frame_err;
    w_status[ST_TX_DROP]   = r_tx_drop;
  end

  always_comb begin
    w_din = '0;
    if (w_rd_data) w_din = r_rx_valid ? r_rx_data : 8'h00;
    else if (w_rd_stat) w_din = w_status;
`ifdef IO_UART_LOOPBACK_EN
    else if (io_inp && io_n == IO_N_LOOPBACK) w_din = {7'b0, r_loopback};
`endif
  end

  assign io_din = w_din;
  assign ef     = {2'b00, w_fifo_full, r_rx_valid};

endmodule

// File: tb/tb_io_uart.sv
// tb/tb_io_uart.sv - scoreboard bench for io_uart (CLKS_PER_BIT=8, TX_DEPTH=4)
module tb_io_uart;

  logic       clock = 1'b0;
  logic       resetq;
  logic [2:0] io_n;
  logic       io_inp, io_out;
  logic [7:0] io_dout;
  logic [7:0] io_din;
  logic [3:0] ef;
  logic       uart_tx;
  logic       uart_rx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  int         starts[$];

  logic [7:0] mon_b;
  logic       mon_ab;
  int         mon_start;

  io_uart #(.CLKS_PER_BIT(8), .TX_DEPTH(4), .PORT_DATA(1), .PORT_STATUS(2)) dut (
    .clock   (clock),
    .resetq  (resetq),
    .io_n    (io_n),
    .io_inp  (io_inp),
    .io_out  (io_out),
    .io_dout (io_dout),
    .io_din  (io_din),
    .ef      (ef),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Read monitor: every INP strobe consumes one expected io_din value.
  always @(negedge clock) begin
    if (io_inp === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=%h expected=none", io_din);
      end else check("rd_data", io_din, rd_q.pop_front());
    end
  end

  // Line monitor: decodes frames on uart_tx, sampling mid-bit; frames cut by reset are discarded.
  always begin
    @(negedge clock);
    if (resetq === 1'b1 && uart_tx === 1'b0) begin
      mon_start = cyc;
      mon_ab = 1'b0;
      repeat (3) @(negedge clock);
      if (!resetq) mon_ab = 1'b1;
      for (int j = 0; j < 8; j++) begin
        repeat (8) @(negedge clock);
        if (!resetq) mon_ab = 1'b1;
        mon_b[j] = uart_tx;
      end
      repeat (8) @(negedge clock);
      if (!resetq) mon_ab = 1'b1;
      if (!mon_ab) begin
        check("tx_stop", {7'b0, uart_tx}, 8'h01);
        starts.push_back(mon_start);
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%h expected=none", mon_b);
        end else check("tx_byte", mon_b, tx_q.pop_front());
      end
    end
  end

  task automatic io_write(input logic [2:0] n, input logic [7:0] d);
    @(posedge clock); #1;
    io_n = n; io_dout = d; io_out = 1'b1;
    @(posedge clock); #1;
    io_out = 1'b0; io_n = 3'd0;
  endtask

  task automatic io_read(input logic [2:0] n, input logic [7:0] exp);
    rd_q.push_back(exp);
    @(posedge clock); #1;
    io_n = n; io_inp = 1'b1;
    @(posedge clock); #1;
    io_inp = 1'b0; io_n = 3'd0;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(posedge clock); #1 uart_rx = 1'b0;
    for (int j = 0; j < 8; j++) begin
      repeat (8) @(posedge clock);
      #1 uart_rx = b[j];
    end
    repeat (8) @(posedge clock);
    #1 uart_rx = stop;
    repeat (8) @(posedge clock);
    #1 uart_rx = 1'b1;
  endtask

  task automatic wait_tx_done(input int budget);
    int n = 0;
    while (tx_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      failures++;
      $display("FAIL tx_timeout pending=%0d expected=0", tx_q.size());
    end
    repeat (10) @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    resetq = 1'b0; io_n = 3'd0; io_inp = 1'b0; io_out = 1'b0; io_dout = 8'h00; uart_rx = 1'b1;
    repeat (3) @(posedge clock); #1;
    check("reset_uart_tx", {7'b0, uart_tx}, 8'h01);
    check("reset_ef", {4'b0, ef}, 8'h00);
    resetq = 1'b1;
    io_read(3'd2, 8'h04);

    // Single byte: fall one edge after the push, STOP still active 79 clocks later.
    tx_q.push_back(8'h55);
    io_write(3'd1, 8'h55);
    check("tx_not_yet", {7'b0, uart_tx}, 8'h01);
    @(posedge clock); #1;
    check("tx_fall", {7'b0, uart_tx}, 8'h00);
    repeat (78) @(posedge clock);
    io_read(3'd2, 8'h00);
    io_read(3'd2, 8'h04);
    wait_tx_done(200);

    // Burst behind a busy transmitter: 0x01..0x04 fill the FIFO, 0x05 dropped.
    starts.delete();
    tx_q.push_back(8'h00);
    for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
    io_write(3'd1, 8'h00);
    for (int i = 1; i <= 5; i++) io_write(3'd1, 8'(i));
    check("burst_ef_full", {4'b0, ef}, 8'h02);
    wait_tx_done(600);
    check("burst_frames", 8'(starts.size()), 8'd5);
    for (int i = 1; i < starts.size(); i++) check("burst_gap", 8'(starts[i] - starts[i-1]), 8'd80);
    io_read(3'd2, 8'h24);
    io_read(3'd2, 8'h04);

    // Unmatched strobes do nothing; port 3 behaviour depends on build.
    io_write(3'd5, 8'h33);
    io_read(3'd0, 8'h00);
    io_read(3'd6, 8'h00);
`ifdef IO_UART_LOOPBACK_EN
    io_write(3'd3, 8'h01);
    io_read(3'd3, 8'h01);
    io_write(3'd1, 8'h7E);
    lows = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clock);
      if (!uart_tx) lows++;
    end
    check("lb_tx_held", 8'(lows), 8'd0);
    io_read(3'd1, 8'h7E);
    io_write(3'd3, 8'h00);
    io_read(3'd3, 8'h00);
`else
    io_write(3'd3, 8'h01);
    io_read(3'd3, 8'h00);
    repeat (100) @(posedge clock);
`endif
    io_read(3'd2, 8'h04);

    // Receive one byte and consume it.
    uart_send(8'hA3, 1'b1);
    repeat (2) @(posedge clock); #1;
    check("rx_ef_set", {4'b0, ef}, 8'h01);
    io_read(3'd1, 8'hA3);
    check("rx_ef_clr", {4'b0, ef}, 8'h00);
    io_read(3'd1, 8'h00);

    // Overrun keeps the first byte.
    uart_send(8'h11, 1'b1);
    uart_send(8'h22, 1'b1);
    repeat (2) @(posedge clock);
    io_read(3'd1, 8'h11);
    io_read(3'd2, 8'h0C);
    io_read(3'd2, 8'h04);

    // Framing error, then a short glitch.
    uart_send(8'h5A, 1'b0);
    repeat (2) @(posedge clock); #1;
    check("ferr_ef", {4'b0, ef}, 8'h00);
    io_read(3'd2, 8'h14);
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (2) @(posedge clock);
    #1 uart_rx = 1'b1;
    repeat (100) @(posedge clock); #1;
    check("glitch_ef", {4'b0, ef}, 8'h00);
    io_read(3'd2, 8'h04);

    // Reset in the middle of a transmitted frame.
    io_write(3'd1, 8'h00);
    repeat (20) @(posedge clock);
    #1 resetq = 1'b0;
    @(posedge clock); #1;
    check("midreset_tx", {7'b0, uart_tx}, 8'h01);
    check("midreset_ef", {4'b0, ef}, 8'h00);
    resetq = 1'b1;
    repeat (100) @(posedge clock);
    io_read(3'd2, 8'h04);
    check("tx_q_empty", 8'(tx_q.size()), 8'd0);
    check("rd_q_empty", 8'(rd_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
